event_responder: RTL and testbench

//   Consumer end of a named-event handshake. Takes single-cycle trigger pulses

---
 rtl/event_responder_if.sv | 32 +++
 rtl/event_responder.sv | 107 ++++++++++
 tb/tb_event_responder.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/event_responder_if.sv
// Event handshake bundle between an event generator and the responder.
// The generator side drives the trigger; the responder side drives the
// response pulse, its status and its statistics counters.
interface event_responder_if #(
  parameter int PEND_W = 3,
  parameter int CNT_W  = 8
);
  logic              trig;
  logic              resp;
  logic              busy;
  logic [PEND_W-1:0] pend;
  logic [CNT_W-1:0]  resp_cnt;
  logic [CNT_W-1:0]  drop_cnt;

  modport master (
    output trig,
    input  resp,
    input  busy,
    input  pend,
    input  resp_cnt,
    input  drop_cnt
  );

  modport slave (
    input  trig,
    output resp,
    output busy,
    output pend,
    output resp_cnt,
    output drop_cnt
  );
endinterface

// File: rtl/event_responder.sv
// Consumer end of a named-event handshake. Each accepted trigger is served
// for DELAY clocks and answered with a one-cycle response pulse. Triggers
// arriving during service are queued in a pending counter up to
// 2**PEND_W-1; further ones are dropped and counted. Both statistics
// counters saturate at all-ones.
module event_responder #(
  parameter int DELAY  = 1,
  parameter int PEND_W = 3,
  parameter int CNT_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  event_responder_if.slave   ev
);

  // The timer only ever holds DELAY-1 down to 0.
  localparam int TW = (DELAY > 1) ? $clog2(DELAY) : 1;
  localparam logic [TW-1:0]     RELOAD = TW'(DELAY - 1);
  localparam logic [PEND_W-1:0] PMAX   = {PEND_W{1'b1}};

  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } state_t;

  state_t            state;
  logic [TW-1:0]     timer;
  logic [PEND_W-1:0] pend;
  logic              resp;
  logic              busy;
  logic [CNT_W-1:0]  resp_cnt;
  logic [CNT_W-1:0]  drop_cnt;

  // Saturating increment: the statistics never wrap back to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      return v;
    end else begin
      return v + CNT_W'(1);
    end
  endfunction

  // Service FSM with all outputs registered; reset aborts any service in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      timer    <= {TW{1'b0}};
      pend     <= {PEND_W{1'b0}};
      resp     <= 1'b0;
      busy     <= 1'b0;
      resp_cnt <= {CNT_W{1'b0}};
      drop_cnt <= {CNT_W{1'b0}};
    end else begin
      resp <= 1'b0;
      case (state)
        IDLE: begin
          if (ev.trig) begin
            state <= SERVE;
            timer <= RELOAD;
            busy  <= 1'b1;
          end
        end
        SERVE: begin
          if (timer == {TW{1'b0}}) begin
            // Expiry edge: answer the current service, then decide what follows.
            resp     <= 1'b1;
            resp_cnt <= sat_inc(resp_cnt);
            if (pend != {PEND_W{1'b0}}) begin
              timer <= RELOAD;
              // A trigger on this edge takes the slot the dequeue frees.
              if (!ev.trig) begin
                pend <= pend - PEND_W'(1);
              end
            end else if (ev.trig) begin
              timer <= RELOAD;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            timer <= timer - TW'(1);
            if (ev.trig) begin
              if (pend != PMAX) begin
                pend <= pend + PEND_W'(1);
              end else begin
                drop_cnt <= sat_inc(drop_cnt);
              end
            end
          end
        end
        default: begin
          state <= IDLE;
          timer <= {TW{1'b0}};
          pend  <= {PEND_W{1'b0}};
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign ev.resp     = resp;
  assign ev.busy     = busy;
  assign ev.pend     = pend;
  assign ev.resp_cnt = resp_cnt;
  assign ev.drop_cnt = drop_cnt;

endmodule

// File: tb/tb_event_responder.sv
// Bench for event_responder: four instances with different parameter sets
// share one clock and reset. A directed table, hand-written corner-case
// sequences and a randomized phase are all checked against a reference
// model that tracks service deadlines as absolute edge numbers.
module tb_event_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  event_responder_if #(.PEND_W(3), .CNT_W(8)) if0 ();
  event_responder_if #(.PEND_W(2), .CNT_W(8)) if1 ();
  event_responder_if #(.PEND_W(3), .CNT_W(4)) if2 ();
  event_responder_if #(.PEND_W(3), .CNT_W(8)) if3 ();

  event_responder #(.DELAY(3), .PEND_W(3), .CNT_W(8)) dut0 (.clk(clk), .rst(rst), .ev(if0));
  event_responder #(.DELAY(4), .PEND_W(2), .CNT_W(8)) dut1 (.clk(clk), .rst(rst), .ev(if1));
  event_responder #(.DELAY(1), .PEND_W(3), .CNT_W(4)) dut2 (.clk(clk), .rst(rst), .ev(if2));
  event_responder #(.DELAY(5), .PEND_W(3), .CNT_W(8)) dut3 (.clk(clk), .rst(rst), .ev(if3));

  int passes = 0;
  int total  = 0;

  // Reference model parameters per instance.
  int dly [4] = '{3, 4, 1, 5};
  int pmx [4] = '{7, 3, 7, 7};
  int cmx [4] = '{255, 255, 15, 255};

  // Reference model state: deadline is the edge number at which the
  // current service answers.
  int m_busy [4];
  int m_pend [4];
  int m_dead [4];
  int m_rcnt [4];
  int m_dcnt [4];
  int m_resp [4];
  int cyc = 0;

  typedef struct {
    bit trig;
    int resp;
    int busy;
    int pend;
    int cnt;
  } vec_t;

  vec_t tbl [11];

  task automatic cmp(input string nm, input int act, input int exp);
    total++;
    if (act == exp) begin
      passes++;
    end else begin
      $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, act, exp, cyc - 1);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v >= mx) ? mx : v + 1;
  endfunction

  task automatic model_step(input int k, input bit trig, input bit r);
    if (r) begin
      m_busy[k] = 0; m_pend[k] = 0; m_dead[k] = 0;
      m_rcnt[k] = 0; m_dcnt[k] = 0; m_resp[k] = 0;
    end else begin
      m_resp[k] = 0;
      if (m_busy[k] == 0) begin
        if (trig) begin
          m_busy[k] = 1;
          m_dead[k] = cyc + dly[k];
        end
      end else if (cyc == m_dead[k]) begin
        m_resp[k] = 1;
        m_rcnt[k] = sat(m_rcnt[k], cmx[k]);
        if (m_pend[k] > 0 || trig) begin
          m_dead[k] = cyc + dly[k];
          if (m_pend[k] > 0 && !trig) m_pend[k] = m_pend[k] - 1;
        end else begin
          m_busy[k] = 0;
        end
      end else if (trig) begin
        if (m_pend[k] < pmx[k]) m_pend[k] = m_pend[k] + 1;
        else m_dcnt[k] = sat(m_dcnt[k], cmx[k]);
      end
    end
  endtask

  task automatic check_dut(input int k, input int r, input int b, input int p,
                           input int rc, input int dc);
    cmp($sformatf("dut%0d.resp", k), r, m_resp[k]);
    cmp($sformatf("dut%0d.busy", k), b, m_busy[k]);
    cmp($sformatf("dut%0d.pend", k), p, m_pend[k]);
    cmp($sformatf("dut%0d.resp_cnt", k), rc, m_rcnt[k]);
    cmp($sformatf("dut%0d.drop_cnt", k), dc, m_dcnt[k]);
  endtask

  // One clock edge: apply inputs, advance the model, compare all instances.
  task automatic step(input bit [3:0] t, input bit r);
    if0.trig = t[0];
    if1.trig = t[1];
    if2.trig = t[2];
    if3.trig = t[3];
    rst = r;
    @(posedge clk);
    for (int k = 0; k < 4; k++) model_step(k, t[k], r);
    cyc++;
    #1;
    check_dut(0, int'(if0.resp), int'(if0.busy), int'(if0.pend), int'(if0.resp_cnt), int'(if0.drop_cnt));
    check_dut(1, int'(if1.resp), int'(if1.busy), int'(if1.pend), int'(if1.resp_cnt), int'(if1.drop_cnt));
    check_dut(2, int'(if2.resp), int'(if2.busy), int'(if2.pend), int'(if2.resp_cnt), int'(if2.drop_cnt));
    check_dut(3, int'(if3.resp), int'(if3.busy), int'(if3.pend), int'(if3.resp_cnt), int'(if3.drop_cnt));
  endtask

  task automatic do_reset();
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);
  endtask

  initial begin
    int cnt;
    int maxp;
    int maxd;

    // DELAY=3, triggers on three consecutive edges.
    tbl[0]  = '{1'b1, 0, 1, 0, 0};
    tbl[1]  = '{1'b1, 0, 1, 1, 0};
    tbl[2]  = '{1'b1, 0, 1, 2, 0};
    tbl[3]  = '{1'b0, 1, 1, 1, 1};
    tbl[4]  = '{1'b0, 0, 1, 1, 1};
    tbl[5]  = '{1'b0, 0, 1, 1, 1};
    tbl[6]  = '{1'b0, 1, 1, 0, 2};
    tbl[7]  = '{1'b0, 0, 1, 0, 2};
    tbl[8]  = '{1'b0, 0, 1, 0, 2};
    tbl[9]  = '{1'b0, 1, 0, 0, 3};
    tbl[10] = '{1'b0, 0, 0, 0, 3};

    for (int k = 0; k < 4; k++) model_step(k, 1'b0, 1'b1);
    if0.trig = 1'b0; if1.trig = 1'b0; if2.trig = 1'b0; if3.trig = 1'b0;

    do_reset();
    cmp("reset.busy", int'(if0.busy), 0);
    cmp("reset.resp_cnt", int'(if0.resp_cnt), 0);
    cmp("reset.pend", int'(if1.pend), 0);

    // Directed table on dut0.
    for (int i = 0; i < 11; i++) begin
      step({3'b000, tbl[i].trig}, 1'b0);
      cmp($sformatf("tbl%0d.resp", i), int'(if0.resp), tbl[i].resp);
      cmp($sformatf("tbl%0d.busy", i), int'(if0.busy), tbl[i].busy);
      cmp($sformatf("tbl%0d.pend", i), int'(if0.pend), tbl[i].pend);
      cmp($sformatf("tbl%0d.resp_cnt", i), int'(if0.resp_cnt), tbl[i].cnt);
    end

    // DELAY=4, capacity 3: six back-to-back triggers.
    do_reset();
    maxp = 0;
    for (int i = 0; i < 36; i++) begin
      step({2'b00, (i < 6), 1'b0}, 1'b0);
      if (int'(if1.pend) > maxp) maxp = int'(if1.pend);
    end
    cmp("sat.pend_max", maxp, 3);
    cmp("sat.drop_cnt", int'(if1.drop_cnt), 1);
    cmp("sat.resp_cnt", int'(if1.resp_cnt), 5);
    cmp("sat.busy_end", int'(if1.busy), 0);

    // DELAY=1, trigger held for 20 cycles.
    do_reset();
    cnt = 0; maxp = 0; maxd = 0;
    for (int i = 0; i < 25; i++) begin
      step({1'b0, (i < 20), 2'b00}, 1'b0);
      cnt += int'(if2.resp);
      if (int'(if2.pend) > maxp) maxp = int'(if2.pend);
      if (int'(if2.drop_cnt) > maxd) maxd = int'(if2.drop_cnt);
      if (i >= 1 && i <= 20) cmp($sformatf("b2b.resp%0d", i), int'(if2.resp), 1);
    end
    cmp("b2b.resp_total", cnt, 20);
    cmp("b2b.pend_max", maxp, 0);
    cmp("b2b.drop_max", maxd, 0);

    // CNT_W=4: 20 isolated responses saturate at 15.
    do_reset();
    for (int i = 0; i < 60; i++) step({1'b0, (i % 3 == 0), 2'b00}, 1'b0);
    cmp("satcnt.resp_cnt", int'(if2.resp_cnt), 15);

    // DELAY=5: reset in mid-service, then a fresh trigger.
    do_reset();
    cnt = 0;
    for (int i = 0; i < 3; i++) step({(i < 3), 3'b000}, 1'b0);
    step(4'b0000, 1'b1);
    cmp("abort.busy", int'(if3.busy), 0);
    cmp("abort.pend", int'(if3.pend), 0);
    cmp("abort.resp", int'(if3.resp), 0);
    for (int e = 4; e <= 14; e++) begin
      step({(e == 6), 3'b000}, 1'b0);
      cnt += int'(if3.resp);
      if (e == 11) cmp("abort.resp_e11", int'(if3.resp), 1);
    end
    cmp("abort.resp_total", cnt, 1);
    cmp("abort.resp_cnt", int'(if3.resp_cnt), 1);

    // Randomized traffic with occasional resets.
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      bit [3:0] t;
      int dens;
      dens = (i / 250) % 4;
      for (int k = 0; k < 4; k++) t[k] = ($urandom_range(3, 0) < dens + 1) ? 1'b1 : 1'b0;
      step(t, ($urandom_range(299, 0) == 0));
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
